// File: rtl/prach_nco_mixer.sv
// prach_nco_mixer: TDM NCO downconversion stage for the PRACH chain.
// One phase accumulator per (antenna, carrier); every incoming complex sample
// is rotated by exp(-j*phase) through a four-stage pipeline:
//   stage 1 phase read/update, stage 2 ROM lookup, stage 3 multiply,
//   stage 4 combine/round/saturate.
// Optional build macro PRACH_NCO_DITHER_EN adds LFSR phase dither ahead of the
// ROM address truncation; without it the phase is purely truncated.
module prach_nco_mixer #(
  parameter int NUM_ANT = 8,
  parameter int NUM_CC  = 3,
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 10,
  parameter int COEF_W  = 16
) (
  input  logic                                         clk_dsp,
  input  logic                                         rst_dsp,
  input  logic [NUM_CC-1:0][DATA_W-1:0]                din_dr,
  input  logic [NUM_CC-1:0][DATA_W-1:0]                din_di,
  input  logic                                         din_dv,
  input  logic [7:0]                                   din_chn,
  input  logic                                         sync_in,
  input  logic [NUM_ANT-1:0][NUM_CC-1:0][PHASE_W-1:0]  ctrl_fcw,
  output logic [NUM_CC-1:0][DATA_W-1:0]                dout_dr,
  output logic [NUM_CC-1:0][DATA_W-1:0]                dout_di,
  output logic                                         dout_dv,
  output logic [7:0]                                   dout_chn,
  output logic                                         sync_out,
  output logic                                         err_chn
);

  localparam int  ANT_W  = (NUM_ANT > 1) ? $clog2(NUM_ANT) : 1;
  localparam int  ROM_N  = 1 << LUT_AW;
  localparam int  DITH_W = PHASE_W - LUT_AW;
  localparam int  PROD_W = DATA_W + COEF_W;
  localparam int  SUM_W  = PROD_W + 1;
  localparam real PI     = 3.14159265358979323846;

  localparam logic signed [SUM_W-1:0] RND_HALF =
    {{(SUM_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Elaboration-time ROM coefficient: round-half-away of full-scale cos/sin.
  function automatic logic signed [COEF_W-1:0] rom_coef(input int k, input bit want_sin);
    real ang;
    real v;
    int  q;
    ang = 2.0 * PI * real'(k) / real'(ROM_N);
    v   = real'((2 ** (COEF_W-1)) - 1) * (want_sin ? $sin(ang) : $cos(ang));
    q   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return COEF_W'(q);
  endfunction

  // Clamp a rounded sum into the signed output range.
  function automatic logic [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX)      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
    else                  return v[DATA_W-1:0];
  endfunction

  logic signed [COEF_W-1:0] cos_rom [ROM_N];
  logic signed [COEF_W-1:0] sin_rom [ROM_N];

  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    localparam logic signed [COEF_W-1:0] COS_K = rom_coef(k, 1'b0);
    localparam logic signed [COEF_W-1:0] SIN_K = rom_coef(k, 1'b1);
    assign cos_rom[k] = COS_K;
    assign sin_rom[k] = SIN_K;
  end

  logic                     ch_ok;
  logic [ANT_W-1:0]         ant;
  logic [PHASE_W-1:0]       dith;
  logic [PHASE_W-1:0]       phase_acc [NUM_ANT][NUM_CC];
  logic [PHASE_W-1:0]       phase_eff [NUM_CC];
  logic [LUT_AW-1:0]        addr_next [NUM_CC];

  assign ch_ok = din_dv && ({24'd0, din_chn} < 32'(NUM_ANT));
  assign ant   = din_chn[ANT_W-1:0];

`ifdef PRACH_NCO_DITHER_EN
  logic [15:0] lfsr;

  // Dither source: x^16+x^14+x^13+x^11+1 Fibonacci LFSR, one step per accepted sample.
  always_ff @(posedge clk_dsp) begin
    if (rst_dsp)    lfsr <= 16'hACE1;
    else if (ch_ok) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign dith = PHASE_W'({16'd0, lfsr} & ((32'd1 << DITH_W) - 32'd1));
`else
  assign dith = '0;
`endif

  // Phase used by the current sample (zero under sync) and its ROM address.
  always_comb begin
    for (int c = 0; c < NUM_CC; c++) begin
      phase_eff[c] = (sync_in ? '0 : phase_acc[ant][c]) + dith;
      addr_next[c] = LUT_AW'(phase_eff[c] >> DITH_W);
    end
  end

  // Accumulator update: sync clears everything, a valid sample advances by its FCW.
  always_ff @(posedge clk_dsp) begin
    if (rst_dsp) begin
      for (int a = 0; a < NUM_ANT; a++)
        for (int c = 0; c < NUM_CC; c++)
          phase_acc[a][c] <= '0;
    end else if (sync_in) begin
      for (int a = 0; a < NUM_ANT; a++)
        for (int c = 0; c < NUM_CC; c++)
          phase_acc[a][c] <= (ch_ok && (ant == ANT_W'(a))) ? ctrl_fcw[a][c] : '0;
    end else if (ch_ok) begin
      for (int c = 0; c < NUM_CC; c++)
        phase_acc[ant][c] <= phase_acc[ant][c] + ctrl_fcw[ant][c];
    end
  end

  logic                          s1_dv, s1_sync;
  logic [7:0]                    s1_chn;
  logic [NUM_CC-1:0][DATA_W-1:0] s1_dr, s1_di;
  logic [LUT_AW-1:0]             s1_addr [NUM_CC];

  // Stage 1: capture sample and ROM address; invalid channels are dropped and flagged.
  always_ff @(posedge clk_dsp) begin
    if (rst_dsp) begin
      s1_dv   <= 1'b0;
      s1_sync <= 1'b0;
      s1_chn  <= '0;
      s1_dr   <= '0;
      s1_di   <= '0;
      err_chn <= 1'b0;
      for (int c = 0; c < NUM_CC; c++) s1_addr[c] <= '0;
    end else begin
      s1_dv   <= ch_ok;
      s1_sync <= sync_in;
      s1_chn  <= din_chn;
      s1_dr   <= din_dr;
      s1_di   <= din_di;
      err_chn <= err_chn | (din_dv & ~ch_ok);
      for (int c = 0; c < NUM_CC; c++) s1_addr[c] <= addr_next[c];
    end
  end

  logic                     s2_dv, s2_sync;
  logic [7:0]               s2_chn;
  logic signed [DATA_W-1:0] s2_dr  [NUM_CC];
  logic signed [DATA_W-1:0] s2_di  [NUM_CC];
  logic signed [COEF_W-1:0] s2_cos [NUM_CC];
  logic signed [COEF_W-1:0] s2_sin [NUM_CC];

  // Stage 2: sine/cosine ROM lookup.
  always_ff @(posedge clk_dsp) begin
    if (rst_dsp) begin
      s2_dv   <= 1'b0;
      s2_sync <= 1'b0;
      s2_chn  <= '0;
      for (int c = 0; c < NUM_CC; c++) begin
        s2_dr[c]  <= '0;
        s2_di[c]  <= '0;
        s2_cos[c] <= '0;
        s2_sin[c] <= '0;
      end
    end else begin
      s2_dv   <= s1_dv;
      s2_sync <= s1_sync;
      s2_chn  <= s1_chn;
      for (int c = 0; c < NUM_CC; c++) begin
        s2_dr[c]  <= s1_dr[c];
        s2_di[c]  <= s1_di[c];
        s2_cos[c] <= cos_rom[s1_addr[c]];
        s2_sin[c] <= sin_rom[s1_addr[c]];
      end
    end
  end

  logic                     s3_dv, s3_sync;
  logic [7:0]               s3_chn;
  logic signed [PROD_W-1:0] s3_rc [NUM_CC];
  logic signed [PROD_W-1:0] s3_is [NUM_CC];
  logic signed [PROD_W-1:0] s3_ic [NUM_CC];
  logic signed [PROD_W-1:0] s3_rs [NUM_CC];

  // Stage 3: the four full-precision signed products per lane.
  always_ff @(posedge clk_dsp) begin
    if (rst_dsp) begin
      s3_dv   <= 1'b0;
      s3_sync <= 1'b0;
      s3_chn  <= '0;
      for (int c = 0; c < NUM_CC; c++) begin
        s3_rc[c] <= '0;
        s3_is[c] <= '0;
        s3_ic[c] <= '0;
        s3_rs[c] <= '0;
      end
    end else begin
      s3_dv   <= s2_dv;
      s3_sync <= s2_sync;
      s3_chn  <= s2_chn;
      for (int c = 0; c < NUM_CC; c++) begin
        s3_rc[c] <= PROD_W'(s2_dr[c]) * PROD_W'(s2_cos[c]);
        s3_is[c] <= PROD_W'(s2_di[c]) * PROD_W'(s2_sin[c]);
        s3_ic[c] <= PROD_W'(s2_di[c]) * PROD_W'(s2_cos[c]);
        s3_rs[c] <= PROD_W'(s2_dr[c]) * PROD_W'(s2_sin[c]);
      end
    end
  end

  logic signed [SUM_W-1:0] sum_r [NUM_CC];
  logic signed [SUM_W-1:0] sum_i [NUM_CC];
  logic signed [SUM_W-1:0] rnd_r [NUM_CC];
  logic signed [SUM_W-1:0] rnd_i [NUM_CC];
  logic [DATA_W-1:0]       res_r [NUM_CC];
  logic [DATA_W-1:0]       res_i [NUM_CC];

  // Combine products at full width, round half up, then saturate.
  always_comb begin
    for (int c = 0; c < NUM_CC; c++) begin
      sum_r[c] = {s3_rc[c][PROD_W-1], s3_rc[c]} + {s3_is[c][PROD_W-1], s3_is[c]};
      sum_i[c] = {s3_ic[c][PROD_W-1], s3_ic[c]} - {s3_rs[c][PROD_W-1], s3_rs[c]};
      rnd_r[c] = (sum_r[c] + RND_HALF) >>> (COEF_W-1);
      rnd_i[c] = (sum_i[c] + RND_HALF) >>> (COEF_W-1);
      res_r[c] = saturate(rnd_r[c]);
      res_i[c] = saturate(rnd_i[c]);
    end
  end

  // Stage 4: output registers; data and channel hold their last value when idle.
  always_ff @(posedge clk_dsp) begin
    if (rst_dsp) begin
      dout_dv  <= 1'b0;
      sync_out <= 1'b0;
      dout_chn <= '0;
      dout_dr  <= '0;
      dout_di  <= '0;
    end else begin
      dout_dv  <= s3_dv;
      sync_out <= s3_sync;
      if (s3_dv) begin
        dout_chn <= s3_chn;
        for (int c = 0; c < NUM_CC; c++) begin
          dout_dr[c] <= res_r[c];
          dout_di[c] <= res_i[c];
        end
      end
    end
  end

endmodule
